wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the single register-file write port between the
// pipeline W stage and a 2-deep queue of long-latency (mul/div) results.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_vld,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        lu_vld,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_rdy,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        insn_vld,
    output logic        pipe_stall
);

    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIM);

    typedef enum logic {
        NORM  = 1'b0,
        FORCE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic [RD_W-1:0]     fifo_rd_q   [2];
    logic [DATA_W-1:0]   fifo_data_q [2];

    logic                rf_we_q, rf_we_d;
    logic [RD_W-1:0]     rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic                insn_vld_q, insn_vld_d;
    logic                pipe_stall_q, pipe_stall_d;

    logic                enq;
    logic                deq;
    logic                fifo_ne;
    logic                gnt;
    logic [RD_W-1:0]     gnt_rd;
    logic [DATA_W-1:0]   gnt_data;
    logic [CNT_W-1:0]    starve_inc;

    // Ready depends only on occupancy so the producer never sees a combinational loop.
    assign lu_rdy     = (cnt_q != 2'd2);
    assign enq        = lu_vld && lu_rdy;
    assign fifo_ne    = (cnt_q != 2'd0);
    assign starve_inc = starve_q + CNT_W'(1);

    always_comb begin
        state_d      = NORM;
        deq          = 1'b0;
        gnt          = 1'b0;
        gnt_rd       = pipe_rd;
        gnt_data     = pipe_data;
        starve_d     = starve_q;
        insn_vld_d   = 1'b0;
        pipe_stall_d = 1'b0;

        case (state_q)
            NORM: begin
                insn_vld_d = pipe_vld;
                if (pipe_vld && pipe_we) begin
                    gnt = 1'b1;
                end else if (fifo_ne) begin
                    gnt      = 1'b1;
                    deq      = 1'b1;
                    gnt_rd   = fifo_rd_q[rd_ptr_q];
                    gnt_data = fifo_data_q[rd_ptr_q];
                end
                // The starving cycle that makes the count hit the limit is the last one:
                // the very next cycle is spent in FORCE.
                if (!fifo_ne || deq) begin
                    starve_d = '0;
                end else if (starve_inc == LIM_C) begin
                    starve_d     = '0;
                    state_d      = FORCE;
                    pipe_stall_d = 1'b1;
                end else begin
                    starve_d = starve_inc;
                end
            end
            FORCE: begin
                if (fifo_ne) begin
                    gnt      = 1'b1;
                    deq      = 1'b1;
                    gnt_rd   = fifo_rd_q[rd_ptr_q];
                    gnt_data = fifo_data_q[rd_ptr_q];
                end
                starve_d = '0;
                state_d  = NORM;
            end
            default: begin
                state_d = NORM;
            end
        endcase
    end

    // Queue bookkeeping and the registered write-port image.
    always_comb begin
        cnt_d      = cnt_q + 2'(enq) - 2'(deq);
        wr_ptr_d   = wr_ptr_q ^ enq;
        rd_ptr_d   = rd_ptr_q ^ deq;
        rf_we_d    = gnt && (gnt_rd != '0);
        rf_rd_d    = gnt ? gnt_rd : rf_rd_q;
        rf_wdata_d = gnt ? gnt_data : rf_wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= NORM;
            cnt_q        <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            starve_q     <= '0;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wdata_q   <= '0;
            insn_vld_q   <= 1'b0;
            pipe_stall_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            starve_q     <= starve_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
            insn_vld_q   <= insn_vld_d;
            pipe_stall_q <= pipe_stall_d;
            if (enq) begin
                fifo_rd_q[wr_ptr_q]   <= lu_rd;
                fifo_data_q[wr_ptr_q] <= lu_data;
            end
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_wdata   = rf_wdata_q;
    assign insn_vld   = insn_vld_q;
    assign pipe_stall = pipe_stall_q;

endmodule
